uart_tx_serializer: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_serializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line levels and parity-select encoding
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    typedef enum logic {
        UART_PAR_EVEN = 1'b0,
        UART_PAR_ODD  = 1'b1
    } uart_par_sel_e;

    // Parity line level from the XOR of all data bits and the selected sense.
    function automatic logic uart_par_bit(input logic data_xor, input uart_par_sel_e sel);
        return data_xor ^ logic'(sel);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a one-cycle bit_end pulse
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last_cnt;

    // A divisor of zero behaves exactly like one.
    assign last_cnt = (div == '0) ? '0 : div - DIV_W'(1);
    assign bit_end  = en && (cnt_q == last_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load || !en || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - FIFO-fed UART transmit engine, LSB-first framing
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             rd_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             par_en,
    input  logic             par_odd,
    input  logic             stop2,
    output logic             tx,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    uart_tx_state_e   state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             par_acc_q;
    logic [DIV_W-1:0] div_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic             stop2_q;
    logic             tx_q;
    logic             rd_en_q;
    logic             busy_q;

    logic             baud_en;
    logic             baud_load;
    logic             bit_end;

    assign baud_en   = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign baud_load = (state_q == ST_LOAD);

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk     (rd_clk),
        .rst     (rst),
        .en      (baud_en),
        .load    (baud_load),
        .div     (div_q),
        .bit_end (bit_end)
    );

    // Outputs are set one cycle ahead so that tx/rd_en/busy come straight from flops.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_acc_q <= 1'b0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= UART_IDLE_LVL;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= UART_IDLE_LVL;
                    if (!fifo_empty) begin
                        state_q <= ST_FETCH;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_q   <= fifo_data;
                    div_q     <= baud_div;
                    par_en_q  <= par_en;
                    par_odd_q <= par_odd;
                    stop2_q   <= stop2;
                    par_acc_q <= 1'b0;
                    bit_cnt_q <= '0;
                    tx_q      <= UART_START_LVL;
                    state_q   <= ST_START;
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        par_acc_q <= par_acc_q ^ shift_q[0];
                        shift_q   <= shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            if (par_en_q) begin
                                tx_q    <= uart_par_bit(par_acc_q ^ shift_q[0],
                                                        uart_par_sel_e'(par_odd_q));
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= UART_IDLE_LVL;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= UART_IDLE_LVL;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // bit_cnt_q doubles as the stop-bit counter for two-stop frames.
                    if (bit_end) begin
                        if (stop2_q && (bit_cnt_q == '0)) begin
                            bit_cnt_q <= CNT_W'(1);
                        end else begin
                            bit_cnt_q <= '0;
                            if (!fifo_empty) begin
                                state_q <= ST_FETCH;
                                rd_en_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= UART_IDLE_LVL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx    = tx_q;
    assign rd_en = rd_en_q;
    assign busy  = busy_q;

endmodule
